louis_clock_tracker: RTL and testbench
======================================

# louis_clock_tracker

Checks the timing-strobe interface driven by the 50 MHz clock divider on the receive side of the DAC sanity design. Samples `sam_clk_ena` and `sym_clk_ena`, aligns a local replica of the divider's phase counter to them, and declares lock. Regenerates the 4-bit clock phase and flags every cycle where the strobes deviate from the expected pattern. Used by downstream sample/symbol logic and by the sanity bench as a live timing monitor.

## Interface
- `LOCK_COUNT`, default 4: consecutive clean symbol periods needed to declare lock.
- `LOSS_COUNT`, default 2: consecutive bad symbol periods that drop lock.
- `ERR_CNT_W`, default 16: width of the saturating error counter.
- `clock_50`  in  1  system clock; all strobes are synchronous to it.
- `reset`  in  1  asynchronous, active-high reset.
- `sam_clk_ena`  in  1  sample strobe: high 2 cycles out of every 8.
- `sym_clk_ena`  in  1  symbol strobe: high 2 cycles out of every 32, coincident with a `sam_clk_ena` pulse.
- `err_clr`  in  1  synchronous clear of `err_count`.
- `locked`  out  1  tracker in LOCKED state.
- `phase_est`  out  4  regenerated clock phase; valid while `locked`.
- `sam_err`  out  1  one-cycle flag: `sam_clk_ena` mismatched expectation.
- `sym_err`  out  1  one-cycle flag: `sym_clk_ena` mismatched expectation.
- `err_count`  out  ERR_CNT_W  saturating count of mismatch cycles.

## Operation
- Local 5-bit position counter `c`. `c`=0 marks the first cycle of a `sym_clk_ena` pulse. Increments every cycle and wraps 31→0.
- Expected pattern at position `c`:
  - sym high iff `c`∈{0,1}.
  - sam high iff `c[2:0]`∈{0,1}.
  - phase = (`c[4:1]` − 1) mod 16, so the phase is 15 during the sym pulse and 0 on the next two cycles.
- Rising edge: `sym_clk_ena`=1 and its previous-cycle sample =0. The previous-sample register resets to 0.
- Mismatch cycle: in VERIFY or LOCKED, either input differs from its expected value at the current `c`.
- Clean period: `c` reaches 31 with no mismatch since `c`=0.
- State SEARCH:
  - `c` is held at 0.
  - On a rising edge, go to VERIFY with `c`←1 and the good-period count cleared.
- State VERIFY:
  - On any mismatch, go to SEARCH.
  - If that same cycle is itself a rising edge, realign instead: stay in VERIFY with `c`←1 and the good count cleared.
  - Each clean period increments the good count. Reaching LOCK_COUNT moves to LOCKED.
- State LOCKED:
  - A period containing ≥1 mismatch increments the bad count. A clean period clears it.
  - When the bad count reaches LOSS_COUNT (evaluated at `c`=31), go to SEARCH.
  - No realignment happens while locked.
- `err_count` increments by 1 per mismatch cycle and saturates at all-ones.
  - `err_clr` has priority: it forces the next value to 0 even during a mismatch cycle.
- `sam_err` and `sym_err` are asserted independently. Both may be high in the same cycle; that counts as one increment.
- Reset release while `sym_clk_ena` is mid-pulse: a false edge is taken and a mismatch follows at `c`=1. The tracker returns to SEARCH and aligns on the next genuine edge. This is required behaviour.

## Timing
- All outputs are registered and reflect the input sample of the previous cycle (latency 1).
- While locked, `phase_est` equals the divider's phase output delayed by 1 cycle.
- On reset, every output is 0, state is SEARCH, `c`=0, and the good and bad counts are 0. Reset takes effect asynchronously, mid-operation included.
- With ideal strobes and first rising-edge sample at cycle t0, `locked` rises at t0+128 when LOCK_COUNT=4.
- Lock drop: `locked` falls 1 cycle after the `c`=31 sample of the LOSS_COUNT-th consecutive bad period.
- `phase_est` is 0 whenever `locked`=0.

## Structure
- Package `louis_clock_pkg` holds:
  - state enum (SEARCH, VERIFY, LOCKED);
  - constants SAM_PERIOD=8, SYM_PERIOD=32, ENA_WIDTH=2;
  - default LOCK_COUNT and LOSS_COUNT values.
- One sub-module, `louis_clock_pattern`: a combinational replica mapping `c` to expected sam, expected sym and phase. It keeps the pattern definition in one place, shared with the bench model.

## Test plan
- Ideal divider model driving the strobes from reset release → `locked` rises 128 cycles after the first sym rising edge. No error flags. `err_count`=0.
- While locked, compare `phase_est` against the divider phase delayed 1 cycle over 1000 cycles → exact match every cycle.
- Suppress one non-symbol `sam_clk_ena` pulse while locked → `sam_err` high 2 cycles, `err_count`=2, `locked` stays 1.
- Delay the sym/sam pattern by 4 cycles permanently while locked → `locked` falls after the second bad period, then rises again exactly 128 cycles after the first shifted rising edge.
- Assert `reset` mid-LOCKED between clock edges → all outputs 0 immediately. Relock follows after release.
- ERR_CNT_W=4 with continuous mismatch → `err_count` stops at 15. `err_clr` asserted during a mismatch cycle → 0 on the next cycle.

Source files
------------

// File: rtl/louis_clock_pkg.sv
// -----------------------------------------------------------------------------
// louis_clock_pkg
// Shared definitions for the clock-strobe tracker: tracker state encoding,
// divider timing constants and default lock/loss thresholds.
// -----------------------------------------------------------------------------
package louis_clock_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int unsigned SAM_PERIOD = 8;
  localparam int unsigned SYM_PERIOD = 32;
  localparam int unsigned ENA_WIDTH  = 2;

  // Width of the local position counter covering one symbol period.
  localparam int unsigned POS_W = $clog2(SYM_PERIOD);

  localparam int unsigned DEF_LOCK_COUNT = 4;
  localparam int unsigned DEF_LOSS_COUNT = 2;

endpackage

// File: rtl/louis_clock_pattern.sv
// -----------------------------------------------------------------------------
// louis_clock_pattern
// Combinational replica of the 50 MHz divider: maps a position within the
// symbol period to the expected strobe levels and the divider clock phase.
//   i_pos      position in the symbol period (0 = first cycle of sym pulse)
//   o_exp_sam  expected sam_clk_ena level at i_pos
//   o_exp_sym  expected sym_clk_ena level at i_pos
//   o_phase    divider phase at i_pos (15 during the sym pulse)
// -----------------------------------------------------------------------------
module louis_clock_pattern
  import louis_clock_pkg::*;
(
  input  logic [POS_W-1:0] i_pos,
  output logic             o_exp_sam,
  output logic             o_exp_sym,
  output logic [3:0]       o_phase
);

  always_comb begin
    o_exp_sym = (32'(i_pos) < ENA_WIDTH);
    o_exp_sam = ((32'(i_pos) % SAM_PERIOD) < ENA_WIDTH);
    o_phase   = i_pos[POS_W-1:1] - 4'd1;
  end

endmodule

// File: rtl/louis_clock_tracker.sv
// -----------------------------------------------------------------------------
// louis_clock_tracker
// Aligns a local replica of the divider position counter to the incoming
// sample/symbol strobes, declares lock after LOCK_COUNT clean symbol periods,
// drops it after LOSS_COUNT consecutive bad periods, regenerates the clock
// phase and flags every cycle where the strobes deviate from the pattern.
//   clock_50     system clock
//   reset        asynchronous active-high reset
//   sam_clk_ena  sample strobe (2 of every 8 cycles)
//   sym_clk_ena  symbol strobe (2 of every 32 cycles)
//   err_clr      synchronous clear of err_count (priority over increment)
//   locked       tracker is in LOCKED
//   phase_est    regenerated divider phase, 0 while not locked
//   sam_err      sam_clk_ena differed from expectation last cycle
//   sym_err      sym_clk_ena differed from expectation last cycle
//   err_count    saturating count of mismatch cycles
// All outputs are registered (one cycle after the sampled strobes).
// -----------------------------------------------------------------------------
module louis_clock_tracker
  import louis_clock_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int unsigned LOSS_COUNT = DEF_LOSS_COUNT,
  parameter int unsigned ERR_CNT_W  = 16
) (
  input  logic                 clock_50,
  input  logic                 reset,
  input  logic                 sam_clk_ena,
  input  logic                 sym_clk_ena,
  input  logic                 err_clr,
  output logic                 locked,
  output logic [3:0]           phase_est,
  output logic                 sam_err,
  output logic                 sym_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BAD_W  = $clog2(LOSS_COUNT + 1);

  state_t               r_state, w_state_nxt;
  logic [POS_W-1:0]     r_pos, w_pos_nxt;
  logic [GOOD_W-1:0]    r_good, w_good_nxt;
  logic [BAD_W-1:0]     r_bad, w_bad_nxt;
  logic                 r_period_bad, w_period_bad_nxt;
  logic                 r_sym_d;
  logic                 r_locked;
  logic [3:0]           r_phase;
  logic                 r_sam_err, r_sym_err;
  logic [ERR_CNT_W-1:0] r_err_cnt, w_err_nxt;

  logic                 w_exp_sam, w_exp_sym;
  logic [3:0]           w_phase;
  logic                 w_rise, w_sam_bad, w_sym_bad, w_mismatch, w_end;

  louis_clock_pattern u_pattern (
    .i_pos     (r_pos),
    .o_exp_sam (w_exp_sam),
    .o_exp_sym (w_exp_sym),
    .o_phase   (w_phase)
  );

  always_comb begin
    w_rise     = sym_clk_ena & ~r_sym_d;
    w_sam_bad  = (r_state != SEARCH) && (sam_clk_ena != w_exp_sam);
    w_sym_bad  = (r_state != SEARCH) && (sym_clk_ena != w_exp_sym);
    w_mismatch = w_sam_bad | w_sym_bad;
    w_end      = (32'(r_pos) == SYM_PERIOD - 1);
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pos_nxt        = r_pos + POS_W'(1);  // wraps naturally at SYM_PERIOD
    w_good_nxt       = r_good;
    w_bad_nxt        = r_bad;
    w_period_bad_nxt = 1'b0;
    case (r_state)
      SEARCH: begin
        w_pos_nxt  = '0;
        w_good_nxt = '0;
        w_bad_nxt  = '0;
        if (w_rise) begin
          w_state_nxt = VERIFY;
          w_pos_nxt   = POS_W'(1);
        end
      end
      VERIFY: begin
        if (w_mismatch) begin
          w_good_nxt = '0;
          // A mismatch that is itself a fresh sym edge realigns in place.
          if (w_rise) begin
            w_pos_nxt = POS_W'(1);
          end else begin
            w_state_nxt = SEARCH;
            w_pos_nxt   = '0;
          end
        end else if (w_end) begin
          if (32'(r_good) + 1 >= LOCK_COUNT) begin
            w_state_nxt = LOCKED;
            w_good_nxt  = '0;
            w_bad_nxt   = '0;
          end else begin
            w_good_nxt = r_good + GOOD_W'(1);
          end
        end
      end
      LOCKED: begin
        w_period_bad_nxt = r_period_bad | w_mismatch;
        if (w_end) begin
          w_period_bad_nxt = 1'b0;
          if (r_period_bad | w_mismatch) begin
            if (32'(r_bad) + 1 >= LOSS_COUNT) begin
              w_state_nxt = SEARCH;
              w_pos_nxt   = '0;
              w_bad_nxt   = '0;
            end else begin
              w_bad_nxt = r_bad + BAD_W'(1);
            end
          end else begin
            w_bad_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = SEARCH;
        w_pos_nxt   = '0;
        w_good_nxt  = '0;
        w_bad_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_err_nxt = r_err_cnt;
    if (err_clr) begin
      w_err_nxt = '0;
    end else if (w_mismatch && (r_err_cnt != '1)) begin
      w_err_nxt = r_err_cnt + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      r_state      <= SEARCH;
      r_pos        <= '0;
      r_good       <= '0;
      r_bad        <= '0;
      r_period_bad <= 1'b0;
      r_sym_d      <= 1'b0;
      r_locked     <= 1'b0;
      r_phase      <= '0;
      r_sam_err    <= 1'b0;
      r_sym_err    <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pos        <= w_pos_nxt;
      r_good       <= w_good_nxt;
      r_bad        <= w_bad_nxt;
      r_period_bad <= w_period_bad_nxt;
      r_sym_d      <= sym_clk_ena;
      r_locked     <= (w_state_nxt == LOCKED);
      r_phase      <= (w_state_nxt == LOCKED) ? w_phase : '0;
      r_sam_err    <= w_sam_bad;
      r_sym_err    <= w_sym_bad;
      r_err_cnt    <= w_err_nxt;
    end
  end

  assign locked    = r_locked;
  assign phase_est = r_phase;
  assign sam_err   = r_sam_err;
  assign sym_err   = r_sym_err;
  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_louis_clock_tracker.sv
// -----------------------------------------------------------------------------
// tb_louis_clock_tracker
// Directed bench: an ideal divider model (position d, optional delay shift,
// sam suppression and sam stuck-high faults) drives the strobes of two
// trackers, the default one and one with a 4-bit error counter.
// -----------------------------------------------------------------------------
module tb_louis_clock_tracker;

  logic        clock_50 = 1'b0;
  logic        reset;
  logic        sam_clk_ena, sym_clk_ena, err_clr;
  logic        locked, sam_err, sym_err;
  logic [3:0]  phase_est;
  logic [15:0] err_count;
  logic        locked4, sam_err4, sym_err4;
  logic [3:0]  phase4;
  logic [3:0]  err_count4;

  int unsigned d, shift;
  bit          sup, stuck, flag_seen;
  logic [3:0]  last_div_phase;
  int          n_cmp, n_bad;

  always #5 clock_50 = ~clock_50;

  louis_clock_tracker u_dut (
    .clock_50    (clock_50),
    .reset       (reset),
    .sam_clk_ena (sam_clk_ena),
    .sym_clk_ena (sym_clk_ena),
    .err_clr     (err_clr),
    .locked      (locked),
    .phase_est   (phase_est),
    .sam_err     (sam_err),
    .sym_err     (sym_err),
    .err_count   (err_count)
  );

  louis_clock_tracker #(.ERR_CNT_W(4)) u_dut4 (
    .clock_50    (clock_50),
    .reset       (reset),
    .sam_clk_ena (sam_clk_ena),
    .sym_clk_ena (sym_clk_ena),
    .err_clr     (err_clr),
    .locked      (locked4),
    .phase_est   (phase4),
    .sam_err     (sam_err4),
    .sym_err     (sym_err4),
    .err_count   (err_count4)
  );

  function automatic logic [3:0] div_phase(int unsigned p);
    return 4'(((p >> 1) + 15) % 16);
  endfunction

  task automatic drive();
    int unsigned p;
    p = (d + 32 - shift) % 32;
    sym_clk_ena = (p < 2);
    sam_clk_ena = stuck | (((p % 8) < 2) & ~sup);
  endtask

  // One clock: remember the divider phase presented at the edge, then
  // advance the divider just after the edge.
  task automatic cyc();
    last_div_phase = div_phase((d + 32 - shift) % 32);
    @(posedge clock_50);
    #1;
    if (sam_err | sym_err) flag_seen = 1'b1;
    d = (d + 1) % 32;
    drive();
  endtask

  task automatic run_to(int unsigned target);
    do cyc(); while (d != target);
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; flag_seen = 1'b0;
    d = 17; shift = 0; sup = 1'b0; stuck = 1'b0;
    err_clr = 1'b0; reset = 1'b1;
    drive();
    #1;
    chk("rst_locked",  32'(locked),    32'd0);
    chk("rst_phase",   32'(phase_est), 32'd0);
    chk("rst_sam_err", 32'(sam_err),   32'd0);
    chk("rst_sym_err", 32'(sym_err),   32'd0);
    chk("rst_errcnt",  32'(err_count), 32'd0);

    // Release reset so the first sampled position is 20; rising edge at 13th.
    repeat (3) cyc();
    reset = 1'b0;
    flag_seen = 1'b0;
    for (int k = 1; k <= 140; k++) begin
      cyc();
      if (k == 139) chk("lock_early", 32'(locked), 32'd0);
      if (k == 140) chk("lock_rise",  32'(locked), 32'd1);
    end
    chk("acq_flags",  32'(flag_seen),  32'd0);
    chk("acq_cnt",    32'(err_count),  32'd0);
    chk("acq_cnt_w4", 32'(err_count4), 32'd0);

    for (int k = 0; k < 1000; k++) begin
      cyc();
      chk("phase", 32'(phase_est), 32'(last_div_phase));
    end
    chk("phase_flags", 32'(flag_seen), 32'd0);

    // Drop the sam pulse at positions 8,9.
    run_to(8);
    sup = 1'b1; drive();
    cyc();
    chk("sup_sam1", 32'(sam_err), 32'd1);
    chk("sup_sym1", 32'(sym_err), 32'd0);
    cyc();
    chk("sup_sam2", 32'(sam_err), 32'd1);
    sup = 1'b0; drive();
    cyc();
    chk("sup_sam3",   32'(sam_err),   32'd0);
    chk("sup_cnt",    32'(err_count), 32'd2);
    chk("sup_locked", 32'(locked),    32'd1);
    run_to(0);
    run_to(0);
    run_to(8);
    chk("sup_hold",     32'(locked),    32'd1);
    chk("sup_cnt_hold", 32'(err_count), 32'd2);

    // Permanent 4-cycle delay starting at position 8.
    shift = 4; drive();
    for (int k = 1; k <= 188; k++) begin
      cyc();
      if (k == 55)  chk("shift_hold",   32'(locked),    32'd1);
      if (k == 56)  chk("shift_drop",   32'(locked),    32'd0);
      if (k == 56)  chk("shift_phase0", 32'(phase_est), 32'd0);
      if (k == 187) chk("relock_early", 32'(locked),    32'd0);
      if (k == 188) chk("relock_rise",  32'(locked),    32'd1);
    end

    // Asynchronous reset between clock edges.
    #2;
    reset = 1'b1;
    #1;
    chk("arst_locked",  32'(locked),     32'd0);
    chk("arst_phase",   32'(phase_est),  32'd0);
    chk("arst_sam",     32'(sam_err),    32'd0);
    chk("arst_sym",     32'(sym_err),    32'd0);
    chk("arst_cnt",     32'(err_count),  32'd0);
    chk("arst_cnt_w4",  32'(err_count4), 32'd0);

    // Release mid-pulse: first sample is the second cycle of the sym pulse.
    do cyc(); while (d != 5);
    reset = 1'b0;
    for (int k = 1; k <= 159; k++) begin
      cyc();
      if (k == 1) chk("mid_sym1", 32'(sym_err), 32'd0);
      if (k == 2) begin
        chk("mid_sym2", 32'(sym_err),   32'd1);
        chk("mid_sam2", 32'(sam_err),   32'd1);
        chk("mid_cnt2", 32'(err_count), 32'd1);
      end
      if (k == 3) begin
        chk("mid_sym3", 32'(sym_err),   32'd0);
        chk("mid_cnt3", 32'(err_count), 32'd1);
      end
      if (k == 158) chk("mid_lock_early", 32'(locked), 32'd0);
      if (k == 159) chk("mid_lock_rise",  32'(locked), 32'd1);
    end

    // sam stuck high: 18 mismatches over positions 0..23 on top of 1.
    stuck = 1'b1; drive();
    repeat (24) cyc();
    chk("sat_w4",    32'(err_count4), 32'd15);
    chk("cnt_w16",   32'(err_count),  32'd19);
    chk("stk_lock",  32'(locked),     32'd1);
    cyc();
    cyc();
    err_clr = 1'b1;
    cyc();
    chk("clr_cnt",    32'(err_count),  32'd0);
    chk("clr_cnt_w4", 32'(err_count4), 32'd0);
    chk("clr_flag",   32'(sam_err),    32'd1);
    err_clr = 1'b0;
    cyc();
    chk("post_clr",    32'(err_count),  32'd1);
    chk("post_clr_w4", 32'(err_count4), 32'd1);
    stuck = 1'b0; drive();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
